register_file_unit: RTL and testbench

//  Next-generation register unit of the processor datapath: PC, AC, AR, DR, IR plus
//  NUM_GPR general registers, all written from the C-bus and read through one

---
 rtl/register_file_unit.sv | 155 +++++++++++++++
 tb/tb_register_file_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/register_file_unit.sv
// rtl/register_file_unit.sv - datapath register file with B-bus mux and request/ack memory port
module register_file_unit #(
   parameter int DATA_LEN        = 16,
   parameter int ADDRESS_LEN     = 8,
   parameter int INSTRUCTION_LEN = 6,
   parameter int NUM_GPR         = 8,
   parameter int C_BUS_LEN       = NUM_GPR + 4,
   parameter int SEL_LEN         = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_LEN-1:0]        c_bus_in,
   input  logic [C_BUS_LEN-1:0]       c_we,
   input  logic [C_BUS_LEN-1:0]       inc,
   input  logic [C_BUS_LEN-1:0]       dec,
   input  logic                       ld_ir,
   input  logic [SEL_LEN-1:0]         select,
   input  logic                       mem_read,
   input  logic                       mem_write,
   input  logic [DATA_LEN-1:0]        mem_rdata,
   input  logic                       mem_ack,
   output logic                       mem_rd_req,
   output logic                       mem_wr_req,
   output logic [ADDRESS_LEN-1:0]     mem_addr,
   output logic [DATA_LEN-1:0]        mem_wdata,
   output logic                       busy,
   output logic                       mem_done,
   output logic [INSTRUCTION_LEN-1:0] ir_out,
   output logic [DATA_LEN-1:0]        ac_out,
   output logic                       ac_zero,
   output logic [DATA_LEN-1:0]        mux_out
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

   state_t                     state_q, state_d;
   logic                       done_q, done_d;
   logic [DATA_LEN-1:0]        ac_q, ac_d, dr_q, dr_d, pc_q, pc_d, mux_q, mux_d;
   logic [ADDRESS_LEN-1:0]     ar_q, ar_d;
   logic [INSTRUCTION_LEN-1:0] ir_q, ir_d;
   logic [DATA_LEN-1:0]        gpr_q [NUM_GPR];
   logic [DATA_LEN-1:0]        gpr_d [NUM_GPR];

   // AR and DR only take direct writes, never inc/dec
   logic unused_incdec;
   assign unused_incdec = ^{inc[2:1], dec[2:1]};

   // Write beats inc/dec; inc and dec together cancel out
   function automatic logic [DATA_LEN-1:0] next_val(input logic [DATA_LEN-1:0] cur,
                                                    input logic we, input logic up,
                                                    input logic down,
                                                    input logic [DATA_LEN-1:0] wdata);
      if (we)
         return wdata;
      else if (up && !down)
         return cur + {{(DATA_LEN-1){1'b0}}, 1'b1};
      else if (down && !up)
         return cur - {{(DATA_LEN-1){1'b0}}, 1'b1};
      else
         return cur;
   endfunction

   assign busy       = (state_q != IDLE);
   assign mem_rd_req = (state_q == RD_WAIT);
   assign mem_wr_req = (state_q == WR_WAIT);
   assign mem_addr   = ar_q;
   assign mem_wdata  = dr_q;
   assign mem_done   = done_q;
   assign ir_out     = ir_q;
   assign ac_out     = ac_q;
   assign ac_zero    = (ac_q == '0);
   assign mux_out    = mux_q;

   // Memory handshake FSM: one outstanding request, new starts ignored while busy
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_read)
               state_d = RD_WAIT;
            else if (mem_write)
               state_d = WR_WAIT;
         end
         RD_WAIT, WR_WAIT: begin
            if (mem_ack) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Register next-state and B-bus source selection from pre-edge values
   always_comb begin
      ac_d = next_val(ac_q, c_we[0], inc[0], dec[0], c_bus_in);
      pc_d = next_val(pc_q, c_we[3], inc[3], dec[3], c_bus_in);
      for (int i = 0; i < NUM_GPR; i++)
         gpr_d[i] = next_val(gpr_q[i], c_we[4+i], inc[4+i], dec[4+i], c_bus_in);

      ar_d = ar_q;
      if (c_we[1] && !busy)
         ar_d = c_bus_in[ADDRESS_LEN-1:0];

      dr_d = dr_q;
      if (state_q == RD_WAIT && mem_ack)
         dr_d = mem_rdata;
      else if (c_we[2] && !busy)
         dr_d = c_bus_in;

      ir_d = ld_ir ? dr_q[INSTRUCTION_LEN-1:0] : ir_q;

      mux_d = '0;
      case (select)
         SEL_LEN'(0): mux_d = dr_q;
         SEL_LEN'(1): mux_d = ac_q;
         SEL_LEN'(2): mux_d = pc_q;
         SEL_LEN'(3): mux_d = {{(DATA_LEN-ADDRESS_LEN){1'b0}}, ar_q};
         default: begin
            for (int i = 0; i < NUM_GPR; i++)
               if (select == SEL_LEN'(4 + i))
                  mux_d = gpr_q[i];
         end
      endcase
   end

   // State and register update; reset abandons any open transaction
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         ac_q    <= '0;
         ar_q    <= '0;
         dr_q    <= '0;
         pc_q    <= '0;
         ir_q    <= '0;
         mux_q   <= '0;
         for (int i = 0; i < NUM_GPR; i++)
            gpr_q[i] <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         ac_q    <= ac_d;
         ar_q    <= ar_d;
         dr_q    <= dr_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         mux_q   <= mux_d;
         for (int i = 0; i < NUM_GPR; i++)
            gpr_q[i] <= gpr_d[i];
      end
   end

endmodule

// File: tb/tb_register_file_unit.sv
// tb/tb_register_file_unit.sv - randomized bench for register_file_unit against a behavioural model
module tb_register_file_unit;
   localparam int C = 12;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] c_bus_in;
   logic [C-1:0] c_we, inc, dec;
   logic        ld_ir;
   logic [3:0]  select;
   logic        mem_read, mem_write;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic        mem_rd_req, mem_wr_req, busy, mem_done, ac_zero;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata, ac_out, mux_out;
   logic [5:0]  ir_out;

   int checks = 0;
   int errors = 0;

   // model: index 0=AC 1=AR 2=DR 3=PC 4+i=Gi; mode 0=idle 1=reading 2=writing
   logic [15:0] m_reg [C];
   logic [5:0]  m_ir;
   logic [15:0] m_mux;
   logic        m_done;
   int          m_mode;

   always #5 clk = ~clk;

   register_file_unit dut (
      .clk(clk), .reset(reset), .c_bus_in(c_bus_in), .c_we(c_we), .inc(inc), .dec(dec),
      .ld_ir(ld_ir), .select(select), .mem_read(mem_read), .mem_write(mem_write),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_rd_req(mem_rd_req),
      .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
      .mem_done(mem_done), .ir_out(ir_out), .ac_out(ac_out), .ac_zero(ac_zero),
      .mux_out(mux_out)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      c_bus_in = '0; c_we = '0; inc = '0; dec = '0; ld_ir = 0; select = '0;
      mem_read = 0; mem_write = 0; mem_rdata = '0; mem_ack = 0;
   endtask

   task automatic model_step();
      logic [15:0] nxt [C];
      logic        was_busy;
      if (reset) begin
         for (int i = 0; i < C; i++) m_reg[i] = '0;
         m_ir = '0; m_mux = '0; m_done = 0; m_mode = 0;
      end else begin
         was_busy = (m_mode != 0);
         for (int i = 0; i < C; i++) begin
            nxt[i] = m_reg[i];
            if (c_we[i] && !(was_busy && (i == 1 || i == 2)))
               nxt[i] = c_bus_in;
            else if (i != 1 && i != 2 && inc[i] && !dec[i])
               nxt[i] = m_reg[i] + 16'd1;
            else if (i != 1 && i != 2 && dec[i] && !inc[i])
               nxt[i] = m_reg[i] - 16'd1;
         end
         nxt[1] = nxt[1] & 16'h00FF;
         if (m_mode == 1 && mem_ack) nxt[2] = mem_rdata;
         if (ld_ir) m_ir = m_reg[2][5:0];
         case (select)
            4'd0: m_mux = m_reg[2];
            4'd1: m_mux = m_reg[0];
            4'd2: m_mux = m_reg[3];
            4'd3: m_mux = m_reg[1];
            default: m_mux = (select < 4'd12) ? m_reg[select] : 16'h0000;
         endcase
         m_done = was_busy && mem_ack;
         if (!was_busy) m_mode = mem_read ? 1 : (mem_write ? 2 : 0);
         else if (mem_ack) m_mode = 0;
         for (int i = 0; i < C; i++) m_reg[i] = nxt[i];
      end
   endtask

   task automatic compare_all();
      check_eq("ac_out", ac_out, m_reg[0]);
      check_eq("ac_zero", ac_zero, m_reg[0] == 16'h0);
      check_eq("mem_addr", mem_addr, m_reg[1]);
      check_eq("mem_wdata", mem_wdata, m_reg[2]);
      check_eq("mux_out", mux_out, m_mux);
      check_eq("ir_out", ir_out, m_ir);
      check_eq("busy", busy, m_mode != 0);
      check_eq("mem_rd_req", mem_rd_req, m_mode == 1);
      check_eq("mem_wr_req", mem_wr_req, m_mode == 2);
      check_eq("mem_done", mem_done, m_done);
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      clear_inputs();
      reset = 1;
      @(negedge clk);
      cycle();
      reset = 0;
      check_eq("rst_ac_zero", ac_zero, 1);
      check_eq("rst_mux", mux_out, 0);

      // G0 write, then read back over the B-bus
      c_we = 12'h010; c_bus_in = 16'h1234; cycle();
      c_we = '0; select = 4'd4; cycle();
      check_eq("g0_mux", mux_out, 16'h1234);

      // PC wraps upward
      c_we = 12'h008; c_bus_in = 16'hFFFF; cycle();
      c_we = '0; inc = 12'h008; cycle();
      inc = '0; select = 4'd2; cycle();
      check_eq("pc_wrap", mux_out, 16'h0000);

      // AC wraps downward, inc+dec holds, write beats inc
      c_we = 12'h001; c_bus_in = 16'h0000; cycle();
      c_we = '0; dec = 12'h001; cycle();
      check_eq("ac_dec_wrap", ac_out, 16'hFFFF);
      inc = 12'h001; cycle();
      check_eq("ac_incdec_hold", ac_out, 16'hFFFF);
      dec = '0; c_we = 12'h001; c_bus_in = 16'h0005; cycle();
      check_eq("ac_we_prio", ac_out, 16'h0005);
      check_eq("ac_zero_low", ac_zero, 0);
      clear_inputs();

      // read with three wait states, DR write attempts ignored while busy
      c_we = 12'h002; c_bus_in = 16'h0010; cycle();
      c_we = '0; mem_read = 1; cycle();
      mem_read = 0;
      check_eq("rd_req_up", mem_rd_req, 1);
      check_eq("rd_addr", mem_addr, 8'h10);
      c_we = 12'h004; c_bus_in = 16'h5555;
      for (int k = 0; k < 3; k++) begin
         cycle();
         check_eq("busy_wait", busy, 1);
      end
      c_we = '0; mem_ack = 1; mem_rdata = 16'hBEEF; cycle();
      mem_ack = 0;
      check_eq("rd_data", mem_wdata, 16'hBEEF);
      check_eq("rd_done", mem_done, 1);
      cycle();
      check_eq("rd_done_pulse", mem_done, 0);

      // read beats write; write during busy dropped
      mem_read = 1; mem_write = 1; cycle();
      check_eq("both_rd", mem_rd_req, 1);
      check_eq("both_wr", mem_wr_req, 0);
      mem_read = 0; cycle();
      mem_write = 0; mem_ack = 1; cycle();
      mem_ack = 0; cycle();
      check_eq("wr_dropped", mem_wr_req, 0);

      // reset mid-read, later ack ignored
      mem_read = 1; cycle();
      mem_read = 0; reset = 1; cycle();
      reset = 0;
      check_eq("rst_rd_req", mem_rd_req, 0);
      check_eq("rst_dr", mem_wdata, 0);
      mem_ack = 1; mem_rdata = 16'hFFFF; cycle();
      mem_ack = 0;
      check_eq("late_ack_dr", mem_wdata, 0);
      check_eq("late_ack_busy", busy, 0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(0, 63) == 0);
         c_bus_in  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         c_we      = C'($urandom & $urandom & $urandom);
         inc       = C'($urandom & $urandom);
         dec       = C'($urandom & $urandom);
         ld_ir     = $urandom_range(0, 3) == 0;
         select    = 4'($urandom);
         mem_read  = $urandom_range(0, 4) == 0;
         mem_write = $urandom_range(0, 4) == 0;
         mem_ack   = $urandom_range(0, 2) == 0;
         mem_rdata = 16'($urandom);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
